// File: rtl/vx_dcr_arb.sv
// Round-robin arbiter merging several DCR write sources onto one registered
// write bus, with atomic multi-beat bursts and a lock watchdog.
`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif

module vx_dcr_arb #(
  parameter int NUM_REQS     = 4,
  parameter int ADDR_WIDTH   = `VX_DCR_ADDR_WIDTH,
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQS-1:0]              req_last,
  output logic [NUM_REQS-1:0]              req_ready,
  output logic                             dcr_write_valid,
  output logic [ADDR_WIDTH-1:0]            dcr_write_addr,
  output logic [DATA_WIDTH-1:0]            dcr_write_data,
  output logic [$clog2(NUM_REQS)-1:0]      grant_id,
  output logic                             locked,
  output logic                             timeout_err
);

  localparam int IW = $clog2(NUM_REQS);
  localparam int CW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    state_r;
  logic [IW-1:0] ptr_r;
  logic [IW-1:0] owner_r;
  logic [CW-1:0] cnt_r;

  logic          rr_found_s;
  logic [IW-1:0] rr_idx_s;
  logic          acc_valid_s;
  logic [IW-1:0] acc_idx_s;
  logic          acc_last_s;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(NUM_REQS - 1)) begin
      return '0;
    end else begin
      return v + IW'(1);
    end
  endfunction

  // First valid source at or after the priority pointer, wrapping upward.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      int idx;
      idx = int'(ptr_r) + i;
      if (idx >= NUM_REQS) begin
        idx = idx - NUM_REQS;
      end else begin
        idx = idx;
      end
      if (!rr_found_s && req_valid[idx]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = IW'(idx);
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Accept selection: a locked owner excludes every other source.
  always_comb begin
    acc_valid_s = 1'b0;
    acc_idx_s   = '0;
    req_ready   = '0;
    if (state_r == ST_LOCKED) begin
      acc_valid_s = req_valid[owner_r];
      acc_idx_s   = owner_r;
    end else begin
      acc_valid_s = rr_found_s;
      acc_idx_s   = rr_idx_s;
    end
    if (acc_valid_s) begin
      req_ready = {{(NUM_REQS-1){1'b0}}, 1'b1} << acc_idx_s;
    end else begin
      req_ready = '0;
    end
    acc_last_s = req_last[acc_idx_s];
  end

  // Arbitration FSM, priority pointer and lock watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      owner_r     <= '0;
      cnt_r       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (acc_valid_s) begin
            if (acc_last_s) begin
              ptr_r <= wrap_inc(acc_idx_s);
            end else begin
              state_r <= ST_LOCKED;
              owner_r <= acc_idx_s;
              cnt_r   <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (acc_valid_s) begin
            if (acc_last_s) begin
              state_r <= ST_IDLE;
              ptr_r   <= wrap_inc(owner_r);
            end else begin
              cnt_r <= '0;
            end
          end else if (cnt_r >= CNT_LAST) begin
            // Owner went quiet for too long: force release.
            state_r     <= ST_IDLE;
            ptr_r       <= wrap_inc(owner_r);
            timeout_err <= 1'b1;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered bus stage; address/data/id hold while no beat is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcr_write_valid <= 1'b0;
      dcr_write_addr  <= '0;
      dcr_write_data  <= '0;
      grant_id        <= '0;
    end else begin
      dcr_write_valid <= acc_valid_s;
      if (acc_valid_s) begin
        dcr_write_addr <= req_addr[acc_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
        dcr_write_data <= req_data[acc_idx_s*DATA_WIDTH +: DATA_WIDTH];
        grant_id       <= acc_idx_s;
      end
    end
  end

  assign locked = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_vx_dcr_arb.sv
// Self-checking bench for vx_dcr_arb: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_vx_dcr_arb;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N-1:0]    req_ready;
  logic            dcr_write_valid;
  logic [AW-1:0]   dcr_write_addr;
  logic [DW-1:0]   dcr_write_data;
  logic [1:0]      grant_id;
  logic            locked;
  logic            timeout_err;

  vx_dcr_arb #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .dcr_write_valid(dcr_write_valid), .dcr_write_addr(dcr_write_addr),
    .dcr_write_data(dcr_write_data), .grant_id(grant_id),
    .locked(locked), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int            m_ptr, m_owner, m_idle;
  bit            m_locked, m_terr;
  bit            exp_valid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int            exp_gid;
  int            last_acc;

  bit pend[N];
  int dly[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 0; m_terr = 0;
    exp_valid = 0; exp_addr = '0; exp_data = '0; exp_gid = 0;
  endtask

  function automatic int model_pick();
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_ptr + k) % N;
      if (req_valid[s]) return s;
    end
    return -1;
  endfunction

  task automatic set_src(input int i, input bit v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit l);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_last[i] = l;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_last  = '0;
  endtask

  // One clock: check ready, advance the model at the edge, check registered outputs.
  task automatic step();
    int acc;
    logic [N-1:0] exp_ready;
    #1;
    acc = model_pick();
    exp_ready = (acc >= 0) ? (N'(1) << acc) : '0;
    chk("req_ready", req_ready, exp_ready);
    @(posedge clk);
    m_terr = 0;
    exp_valid = (acc >= 0);
    if (acc >= 0) begin
      exp_addr = req_addr[acc*AW +: AW];
      exp_data = req_data[acc*DW +: DW];
      exp_gid  = acc;
    end
    if (!m_locked) begin
      if (acc >= 0) begin
        if (req_last[acc]) begin
          m_ptr = (acc + 1) % N;
        end else begin
          m_locked = 1; m_owner = acc; m_idle = 0;
        end
      end
    end else if (acc >= 0) begin
      if (req_last[acc]) begin
        m_locked = 0; m_ptr = (m_owner + 1) % N;
      end else begin
        m_idle = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == T) begin
        m_locked = 0; m_ptr = (m_owner + 1) % N; m_terr = 1;
      end
    end
    last_acc = acc;
    @(negedge clk);
    chk("wr_valid", dcr_write_valid, exp_valid);
    chk("wr_addr", dcr_write_addr, exp_addr);
    chk("wr_data", dcr_write_data, exp_data);
    chk("grant_id", grant_id, exp_gid);
    chk("locked", locked, m_locked);
    chk("timeout_err", timeout_err, m_terr);
  endtask

  // Random sources: hold a request until accepted, then optionally pause.
  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (last_acc == i) begin
        pend[i] = 0;
        if (req_last[i]) dly[i] = $urandom_range(0, 3);
        else if ($urandom_range(0, 5) == 0) dly[i] = $urandom_range(T - 2, T + 2);
        else dly[i] = $urandom_range(0, 2);
      end
      if (!pend[i]) begin
        if (dly[i] > 0) begin
          dly[i]--;
          req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          set_src(i, 1'b1, AW'($urandom), DW'($urandom), ($urandom_range(0, 3) != 0));
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_valid", dcr_write_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single source
    set_src(2, 1'b1, 12'h001, 32'h8000_0000, 1'b1);
    step();
    chk("single_acc", last_acc, 2);
    chk("single_gid", grant_id, 2'd2);
    chk("single_addr", dcr_write_addr, 12'h001);
    chk("single_data", dcr_write_data, 32'h8000_0000);
    clear_all();

    // Round robin from ptr=3: 3,0,1,2,3,0
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(16 + k), DW'(k * 4 + i), 1'b1);
      step();
      chk("rr_gid", grant_id, (3 + k) % 4);
      chk("rr_valid", dcr_write_valid, 1'b1);
    end
    clear_all();

    // Atomic burst from src1 with src0/src3 competing
    set_src(0, 1'b1, 12'h010, 32'h0, 1'b1);
    set_src(3, 1'b1, 12'h030, 32'h3, 1'b1);
    set_src(1, 1'b1, 12'h001, 32'h1111, 1'b0);
    step();
    chk("burst_b0_addr", dcr_write_addr, 12'h001);
    chk("burst_b0_gid", grant_id, 2'd1);
    chk("burst_locked", locked, 1'b1);
    set_src(1, 1'b1, 12'h002, 32'h2222, 1'b1);
    step();
    chk("burst_b1_addr", dcr_write_addr, 12'h002);
    chk("burst_b1_gid", grant_id, 2'd1);
    req_valid[1] = 1'b0;
    step();
    chk("burst_next_gid", grant_id, 2'd3);
    clear_all();

    // Lock timeout
    set_src(0, 1'b1, 12'h005, 32'h5, 1'b0);
    set_src(1, 1'b1, 12'h015, 32'h15, 1'b1);
    step();
    req_valid[0] = 1'b0;
    repeat (T) step();
    chk("to_pulse", timeout_err, 1'b1);
    step();
    chk("to_grant", last_acc, 1);
    chk("to_once", timeout_err, 1'b0);
    clear_all();

    // Owner beat on the exact timeout cycle
    set_src(2, 1'b1, 12'h020, 32'hAAAA, 1'b0);
    step();
    req_valid[2] = 1'b0;
    repeat (T - 1) step();
    set_src(2, 1'b1, 12'h021, 32'hBBBB, 1'b1);
    step();
    chk("bnd_noto", timeout_err, 1'b0);
    chk("bnd_addr", dcr_write_addr, 12'h021);
    chk("bnd_gid", grant_id, 2'd2);
    clear_all();

    // Asynchronous reset during LOCKED
    set_src(3, 1'b1, 12'h033, 32'h3333, 1'b0);
    step();
    chk("rst_pre_locked", locked, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", dcr_write_valid, 1'b0);
    chk("arst_addr", dcr_write_addr, 12'h000);
    chk("arst_data", dcr_write_data, 32'h0);
    chk("arst_gid", grant_id, 2'd0);
    chk("arst_locked", locked, 1'b0);
    chk("arst_terr", timeout_err, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(64 + i), DW'(i), 1'b1);
    step();
    chk("arst_first", last_acc, 0);
    chk("arst_first_valid", dcr_write_valid, 1'b1);
    clear_all();

    // Random traffic
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      dly[i] = 0;
    end
    last_acc = -1;
    repeat (3000) begin
      rand_drive();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
